// File: rtl/stack_data_memory_if.sv
// Request/response bus between the memory stage (master) and the stack data memory (slave).
// The slave also reports its current stack pointer on this bus.
interface stack_data_memory_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [15:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] sp_out;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, sp_out
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, sp_out
   );
endinterface

// File: rtl/stack_data_memory.sv
// Word-addressed data memory with an internal, downward-growing stack and configurable wait states.
// One request is outstanding at a time: IDLE accepts, ACCESS counts wait states, RESP pulses the response.
module stack_data_memory #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int WAIT_STATES = 1,
   parameter int SP_TOP      = (1 << ADDR_W) - 1
) (
   input logic                clk,
   input logic                rst_n,
   stack_data_memory_if.slave bus
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] SP_TOP_C = ADDR_W'(SP_TOP);
   localparam logic [ADDR_W-1:0] SP_ZERO  = '0;
   localparam logic [ADDR_W-1:0] SP_ONE   = ADDR_W'(1);
   localparam logic [3:0]        WAIT_C   = 4'(WAIT_STATES);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_PUSH  = 2'b10;
   localparam logic [1:0] OP_POP   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [15:0]       addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] sp_q, sp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_idx_s;
   logic [DATA_W-1:0] mem_rd_s;
   logic              mem_we_s;
   logic              in_range_s;

   // Address range check and single-port array address select
   always_comb begin
      in_range_s = (17'(addr_q) < 17'(DEPTH));
      mem_idx_s  = '0;
      case (op_q)
         OP_LOAD:  mem_idx_s = addr_q[ADDR_W-1:0];
         OP_STORE: mem_idx_s = addr_q[ADDR_W-1:0];
         OP_PUSH:  mem_idx_s = sp_q;
         OP_POP:   mem_idx_s = sp_q + SP_ONE;
         default:  mem_idx_s = '0;
      endcase
      mem_rd_s = mem_q[mem_idx_s];
   end

   // Next-state, access execution and response generation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      sp_d     = sp_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      valid_d  = 1'b0;
      mem_we_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = WAIT_C;
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               valid_d = 1'b1;
               rdata_d = '0;
               err_d   = 1'b0;
               case (op_q)
                  OP_LOAD: begin
                     if (in_range_s) begin
                        rdata_d = mem_rd_s;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_STORE: begin
                     if (in_range_s) begin
                        mem_we_s = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_PUSH: begin
                     // SP names the next free slot; slot 0 is never pushed so SP cannot wrap
                     if (sp_q != SP_ZERO) begin
                        mem_we_s = 1'b1;
                        sp_d     = sp_q - SP_ONE;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  OP_POP: begin
                     if (sp_q != SP_TOP_C) begin
                        sp_d    = sp_q + SP_ONE;
                        rdata_d = mem_rd_s;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  default: begin
                     err_d = 1'b1;
                  end
               endcase
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control, latched request and response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 2'b00;
         addr_q  <= 16'd0;
         wdata_q <= '0;
         sp_q    <= SP_TOP_C;
         rdata_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sp_q    <= sp_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         valid_q <= valid_d;
      end
   end

   // Array write; a reset on the access edge abandons the write
   always_ff @(posedge clk) begin
      if (mem_we_s && rst_n) begin
         mem_q[mem_idx_s] <= wdata_q;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE) && rst_n;
   assign bus.resp_valid = valid_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.sp_out     = sp_q;

endmodule

// File: tb/tb_stack_data_memory.sv
// Randomized scoreboard bench for stack_data_memory against an array/stack reference model.
module tb_stack_data_memory;
   localparam int WS  = 1;
   localparam int TOP = 4095;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      logic [11:0] sp;
      logic        chk_rdata;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   exp_t        exp_q[$];
   logic [15:0] ref_mem [4096];
   bit          known [4096];
   int          ref_sp;

   stack_data_memory_if #(.ADDR_W(12), .DATA_W(16)) bus ();

   stack_data_memory #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(WS), .SP_TOP(TOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every response pulse is matched against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (bus.resp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp actual=1 required=0 at cyc %0d", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
            chk("resp_sp", 32'(bus.sp_out), 32'(e.sp));
            chk("resp_latency", 32'(cyc), 32'(e.cyc));
            chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
            if (e.chk_rdata) chk("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
         end
      end
   end

   task automatic model(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        output exp_t e);
      e.rdata = 16'd0;
      e.err = 1'b0;
      e.chk_rdata = 1'b1;
      case (op)
         2'b00: begin
            if (addr < 16'd4096) begin
               e.rdata = ref_mem[addr];
               e.chk_rdata = known[addr];
            end else e.err = 1'b1;
         end
         2'b01: begin
            if (addr < 16'd4096) begin
               ref_mem[addr] = wd;
               known[addr] = 1'b1;
            end else e.err = 1'b1;
         end
         2'b10: begin
            if (ref_sp != 0) begin
               ref_mem[ref_sp] = wd;
               known[ref_sp] = 1'b1;
               ref_sp = ref_sp - 1;
            end else e.err = 1'b1;
         end
         default: begin
            if (ref_sp != TOP) begin
               ref_sp = ref_sp + 1;
               e.rdata = ref_mem[ref_sp];
               e.chk_rdata = known[ref_sp];
            end else e.err = 1'b1;
         end
      endcase
      e.sp = 12'(ref_sp);
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = (bus.req_ready === 1'b1);
      if (!ok) chk("ready_timeout", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd);
      exp_t e;
      bit   ok;
      wait_ready(ok);
      if (ok) begin
         model(op, addr, wd, e);
         e.cyc = cyc + WS + 2;
         exp_q.push_back(e);
         bus.req_valid = 1'b1;
         bus.req_op    = op;
         bus.req_addr  = addr;
         bus.req_wdata = wd;
         @(negedge clk);
         bus.req_valid = 1'b0;
         bus.req_op    = 2'($urandom);
         bus.req_addr  = 16'($urandom);
         bus.req_wdata = 16'($urandom);
         chk("ready_in_access", 32'(bus.req_ready), 32'd0);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bit ok;
      checks = 0;
      errors = 0;
      cyc = 0;
      ref_sp = TOP;
      for (int i = 0; i < 4096; i++) known[i] = 1'b0;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op = 2'b00;
      bus.req_addr = 16'd0;
      bus.req_wdata = 16'd0;
      repeat (2) @(negedge clk);
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_sp", 32'(bus.sp_out), 32'hFFF);
      chk("rst_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_rdata", 32'(bus.resp_rdata), 32'd0);
      chk("rst_err", 32'(bus.resp_err), 32'd0);

      issue(2'b01, 16'h010, 16'h1234);
      issue(2'b00, 16'h010, 16'h0000);
      issue(2'b10, 16'h000, 16'hBEEF);
      issue(2'b00, 16'hFFF, 16'h0000);
      issue(2'b10, 16'h000, 16'hCAFE);
      issue(2'b11, 16'h000, 16'h0000);
      issue(2'b11, 16'h000, 16'h0000);
      issue(2'b11, 16'h000, 16'h0000);
      issue(2'b01, 16'h000, 16'hA5A5);
      issue(2'b01, 16'h1000, 16'h9999);
      issue(2'b00, 16'h1000, 16'h0000);
      issue(2'b00, 16'h000, 16'h0000);
      issue(2'b01, 16'h020, 16'h0000);
      issue(2'b10, 16'h000, 16'h7777);
      drain();

      // Abandon a store mid-access with a reset pulse
      wait_ready(ok);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_addr  = 16'h020;
      bus.req_wdata = 16'h5555;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      ref_sp = TOP;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_rst_sp", 32'(bus.sp_out), 32'hFFF);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      chk("mid_rst_valid", 32'(bus.resp_valid), 32'd0);
      issue(2'b00, 16'h020, 16'h0000);

      for (int i = 0; i < 300; i++) begin
         logic [15:0] a;
         if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(4096, 65535));
         else a = 16'($urandom_range(0, 31)) | ($urandom_range(0, 1) == 1 ? 16'hFE0 : 16'h000);
         issue(2'($urandom_range(0, 3)), a, 16'($urandom));
      end

      while (ref_sp != 0) issue(2'b10, 16'h000, 16'($urandom));
      issue(2'b10, 16'h000, 16'hDEAD);
      issue(2'b00, 16'h000, 16'h0000);
      issue(2'b11, 16'h000, 16'h0000);
      issue(2'b00, 16'h001, 16'h0000);
      drain();
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
